// File: rtl/mdu_if.sv
// Pipeline-facing bundle for the mult/div sequencer: command inputs, status, HI/LO.
// MDU_CANCEL_EN adds the cancel (flush) request.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_use;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        done;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        state_dbg;
  logic [3:0]  count_dbg;

  // Command is a single-cycle request: start is sampled at each rising edge, there is
  // no ready; while busy=1 any start is dropped, so the pipeline must stall on md_stall.
`ifdef MDU_CANCEL_EN
  modport master (
    output start, op, src_a, src_b, d_md_use, cancel,
    input  busy, done, md_stall, hi, lo, state_dbg, count_dbg
  );
  modport slave (
    input  start, op, src_a, src_b, d_md_use, cancel,
    output busy, done, md_stall, hi, lo, state_dbg, count_dbg
  );
`else
  modport master (
    output start, op, src_a, src_b, d_md_use,
    input  busy, done, md_stall, hi, lo, state_dbg, count_dbg
  );
  modport slave (
    input  start, op, src_a, src_b, d_md_use,
    output busy, done, md_stall, hi, lo, state_dbg, count_dbg
  );
`endif
endinterface

// File: rtl/mdu_sched.sv
// Fixed-latency multiply/divide sequencer with HI/LO pair for the E stage.
// Optional MDU_CANCEL_EN: cancel input aborts an in-flight op and suppresses a same-cycle start.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [1:0]  op_q;
  logic        done_q;

  logic        take, launch, commit, write_hi, write_lo, cancel_now;

  logic [63:0] prod_s, prod_u;
  logic [31:0] num, den, uq, ur, quo, rem;
  logic        is_div_s;

`ifdef MDU_CANCEL_EN
  assign cancel_now = bus.cancel;
`else
  assign cancel_now = 1'b0;
`endif

  assign take = bus.start & ~cancel_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    launch    = 1'b0;
    commit    = 1'b0;
    write_hi  = 1'b0;
    write_lo  = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          if (!bus.op[2]) begin
            launch    = 1'b1;
            state_nxt = BUSY;
            count_nxt = bus.op[1] ? DIV_LOAD : MULT_LOAD;
          end else if (bus.op == 3'd4) begin
            write_hi = 1'b1;
          end else if (bus.op == 3'd5) begin
            write_lo = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cancel_now) begin
          state_nxt = IDLE;
          count_nxt = 4'd0;
        end else if (count == 4'd1) begin
          commit    = 1'b1;
          state_nxt = IDLE;
          count_nxt = 4'd0;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

  // Signed divide is done on magnitudes and re-signed, so INT_MIN / -1 wraps cleanly.
  always_comb begin
    is_div_s = (op_q == 2'd2);
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    num      = (is_div_s && a_q[31]) ? (32'd0 - a_q) : a_q;
    den      = (is_div_s && b_q[31]) ? (32'd0 - b_q) : b_q;
    uq       = 32'd0;
    ur       = 32'd0;
    if (den != 32'd0) begin
      uq = num / den;
      ur = num % den;
    end
    quo = (is_div_s && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    rem = (is_div_s && a_q[31]) ? (32'd0 - ur) : ur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 2'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      count  <= count_nxt;
      done_q <= commit;
      if (launch) begin
        a_q  <= bus.src_a;
        b_q  <= bus.src_b;
        op_q <= bus.op[1:0];
      end
      if (write_hi) hi_q <= bus.src_a;
      if (write_lo) lo_q <= bus.src_a;
      if (commit) begin
        case (op_q)
          2'd0: {hi_q, lo_q} <= prod_s;
          2'd1: {hi_q, lo_q} <= prod_u;
          default: begin
            if (b_q != 32'd0) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
        endcase
      end
    end
  end

  assign bus.busy      = (state == BUSY);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state_dbg = state;
  assign bus.count_dbg = count;
  // Also covers the cycle a mult/div sits in E before busy rises.
  assign bus.md_stall  = bus.d_md_use & ~cancel_now &
                         ((state == BUSY) | (bus.start & (bus.op <= 3'd3)));

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized + directed bench for mdu_sched against a 64-bit arithmetic reference model.
// Build with +define+MDU_CANCEL_EN to exercise the cancel path.
module tb_mdu_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] op);
    return (op < 3'd2) ? 5 : 10;
  endfunction

  // Architectural effect of a command on HI/LO, from MIPS semantics in 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      q;
    longint      r;
    logic [63:0] p;
    case (op)
      3'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      3'd2: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb; mlo = q[31:0]; mhi = r[31:0];
      end
      3'd3: if (b != 32'd0) begin mlo = a / b; mhi = a % b; end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.op       = 3'd6;
    bus.src_a    = 32'd0;
    bus.src_b    = 32'd0;
    bus.d_md_use = 1'b0;
`ifdef MDU_CANCEL_EN
    bus.cancel   = 1'b0;
`endif
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, mhi});
    check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, mlo});
  endtask

  // Issue one command; inject_at>0 drives a stray DIVU 9/4 in that busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input int inject_at);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.d_md_use = dmd;
    #1 check("stall_start", {63'd0, bus.md_stall}, {63'd0, dmd & (op <= 3'd3)});
    if (op >= 3'd4) begin
      @(negedge clk);
      bus.start = 1'b0;
      model_apply(op, a, b);
      #1;
      check("mt_busy", {63'd0, bus.busy}, 64'd0);
      check("mt_done", {63'd0, bus.done}, 64'd0);
      check_hilo("mt");
    end else begin
      n = latency(op);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        bus.start = 1'b0; bus.op = op; bus.src_a = a; bus.src_b = b;
        #1;
        check("busy_on", {63'd0, bus.busy}, 64'd1);
        check("done_off", {63'd0, bus.done}, 64'd0);
        check("stall_busy", {63'd0, bus.md_stall}, {63'd0, dmd});
        check_hilo("hold");
        if (k == inject_at) begin
          bus.start = 1'b1; bus.op = 3'd3; bus.src_a = 32'd9; bus.src_b = 32'd4;
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
      model_apply(op, a, b);
      #1;
      check("busy_off", {63'd0, bus.busy}, 64'd0);
      check("done_pulse", {63'd0, bus.done}, 64'd1);
      check("stall_after", {63'd0, bus.md_stall}, 64'd0);
      check_hilo("commit");
      @(negedge clk);
      #1 check("done_drop", {63'd0, bus.done}, 64'd0);
    end
    bus.d_md_use = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check_hilo("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 3);
    check("mult_hi_const", {32'd0, bus.hi}, {32'd0, 32'hFFFF_FFFF});
    check("mult_lo_const", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFA});
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("multu_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd0, 1'b1, 0);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b1, 0);
    run_op(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, 0);
    check("mthi_mtlo", {bus.hi, bus.lo}, 64'h1234_5678_A5A5_A5A5);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 0);

    // Abort a DIV in its second busy cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.src_a = 32'hFFFF_FFF9; bus.src_b = 32'd2;
    bus.d_md_use = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1 check("abort_busy", {63'd0, bus.busy}, 64'd1);
    end
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b1;
    #1 check("cancel_stall", {63'd0, bus.md_stall}, 64'd0);
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_done", {63'd0, bus.done}, 64'd0);
    check_hilo("cancel");
    @(negedge clk);
    #1 check("cancel_nodone", {63'd0, bus.done}, 64'd0);
`else
    reset = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    #1;
    check("areset_busy", {63'd0, bus.busy}, 64'd0);
    check("areset_done", {63'd0, bus.done}, 64'd0);
    check_hilo("areset");
    @(negedge clk);
    reset = 1'b1;
`endif
    bus.d_md_use = 1'b0;
    run_op(3'd1, 32'd2, 32'd3, 1'b0, 0);
    check("post_abort", {bus.hi, bus.lo}, 64'd6);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide sequencer with HI/LO register pair. Sits in the E stage of the 5-stage MIPS pipeline.
- Accepts one mult/div/mthi/mtlo command per start pulse, holds busy for a fixed latency, then commits HI/LO.
- Produces the D-stage stall request the hazard unit ORs into pc_en / Instr_D_en / Instr_E_reset.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (legal 1..15)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (legal 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  E-stage instruction is an MDU command; sampled at posedge
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- src_a  in  32  forwarded rs value (MF_rs_E)
- src_b  in  32  forwarded rt value (MF_rt_E)
- d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse after a mult/div commit
- md_stall  out  1  stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, latched operands 0.
- States: IDLE, BUSY. The 4-bit down-counter is valid only in BUSY.
- IDLE, start=1, op in {0..3}:
  - Latch src_a, src_b, op.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Go to BUSY at the same edge.
- IDLE, start=1, op 4/5: at that edge hi<=src_a (MTHI) or lo<=src_a (MTLO). Stay IDLE; busy is not asserted.
- IDLE, start=1, op 6/7: no effect.
- BUSY, each edge: if counter==1, commit result, go to IDLE, done<=1. Otherwise counter decrements.
- busy = (state==BUSY). It is high for exactly N cycles after the start edge (N = latency parameter).
- done is registered: high for the one cycle after the commit edge, otherwise 0. Never set for op 4..7.
- Arithmetic at commit, from latched operands:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divide by zero: hi/lo unchanged, but full DIV_CYCLES busy and done still occur.
- start while BUSY, including the final busy cycle: ignored entirely. Latched operands, counter and hi/lo are untouched. The hazard unit guarantees this cannot happen under correct stalling.
- md_stall = d_md_use & (busy | (start & op<=3)). Combinational.
  - Covers the cycle the command sits in E before busy rises.
  - mfhi/mflo in D is also stalled, so hi/lo are read only after commit.
- hi/lo are plain register outputs. W-stage mfhi/mflo data comes from the E-stage read latched down the pipe, not from this block.
- Reset mid-operation: immediately returns to IDLE, hi/lo cleared, no done pulse.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), for exception/flush support.
  - cancel=1 at an edge while BUSY: go to IDLE, counter 0, hi/lo unchanged, no done.
  - cancel=1 in the same cycle as start: the start is suppressed, including MTHI/MTLO writes.
  - md_stall additionally gated: md_stall = d_md_use & ~cancel & (busy | (start & op<=3)).
- Undefined: port absent; every accepted operation always runs to completion.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3, default params -> busy high cycles 1..5 after start, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once in cycle 6.
- MULTU, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, src_a=-7 (0xFFFFFFF9), src_b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, 7/0 afterwards -> busy 10 cycles, hi/lo unchanged, done pulses.
- MTHI 0x12345678 while IDLE -> hi updated at that edge, busy never asserted, done 0. Then MTLO 0xA5A5A5A5 -> lo updated.
- Stall/ignore: issue MULT, hold d_md_use=1 -> md_stall=1 in the start cycle and all 5 busy cycles, 0 after. A second start (DIVU 9/4) injected in busy cycle 3 is ignored; the final result is the MULT product.
- Pull reset low in busy cycle 2 of a DIV -> busy, done, hi, lo all 0 asynchronously. After release, a new MULTU 2x3 completes with lo=6, hi=0 (with MDU_CANCEL_EN: cancel in busy cycle 2 -> busy 0 next cycle, previous hi/lo retained, no done).
